ct_idu_rf_prf_rd_port: RTL and testbench
========================================

# ct_idu_rf_prf_rd_port

One registered read port of the integer physical register file in the IDU RF stage. It sits directly downstream of the per-preg gated writeback registers and consumes their flattened `reg_dout` outputs. It selects one preg per request and returns its 64-bit value one cycle later. Writebacks landing in the same cycle are bypassed, and the result is held coherently while the consumer stalls.

## Interface
Parameters:
- PREG_NUM, 96, number of physical registers.
- PREG_W, 7, preg index width.
- DATA_W, 64, register width.

Ports:
- forever_cpuclk  in  1  free-running core clock; only clock of the block.
- cpurst  in  1  reset; asynchronous, active-high.
- cp0_idu_icg_en  in  1  module-level clock-gating enable.
- cp0_yy_clk_en  in  1  global clock-gating enable.
- pad_yy_icg_scan_en  in  1  scan override for the gating cell.
- rf_flush  in  1  pipeline flush; kills the in-flight read.
- rf_rd_vld  in  1  read request valid.
- rf_rd_preg  in  PREG_W  requested preg index.
- rf_rd_stall  in  1  consumer not accepting rd_data this cycle.
- prf_preg_dout  in  PREG_NUM*DATA_W  all preg register outputs, preg i at bits [i*64+63:i*64].
- iu_idu_ex2_pipe0_wb_preg_vld / _preg / _data  in  1 / PREG_W / DATA_W  pipe0 writeback.
- iu_idu_ex2_pipe1_wb_preg_vld / _preg / _data  in  1 / PREG_W / DATA_W  pipe1 writeback.
- lsu_idu_wb_pipe3_wb_preg_vld / _preg / _data  in  1 / PREG_W / DATA_W  pipe3 writeback.
- rd_data_vld  out  1  rd_data valid.
- rd_preg  out  PREG_W  preg index of the held result.
- rd_data  out  DATA_W  read result.
- wb_conflict  out  1  sticky error: two writebacks hit the same preg in one cycle.

## Operation
- Accept condition: `accept = rf_rd_vld & ~(rd_data_vld & rf_rd_stall) & ~rf_flush`.
- On accept:
  - rd_preg <= rf_rd_preg.
  - rd_data <= bypass(rf_rd_preg), where bypass is the wb data of the first matching valid port (priority pipe0 > pipe1 > pipe3), else prf_preg_dout[rf_rd_preg].
  - rd_data_vld <= 1.
- Hold: while rd_data_vld & rf_rd_stall, a request is not accepted and upstream keeps it. rd_preg is unchanged.
  - If a wb port matches rd_preg in a hold cycle, rd_data <= that wb data (same priority). Otherwise rd_data is unchanged.
- Idle: with no accept and no hold, rd_data_vld <= 0. rd_data and rd_preg keep their last values.
- Flush: rf_flush forces rd_data_vld <= 0 on the next edge and overrides accept and hold.
- Out-of-range index (rf_rd_preg >= PREG_NUM): rd_data <= 0.
- wb_conflict is set when two or more valid wb ports carry equal preg indices. It stays set until reset.
- Data registers (rd_data, rd_preg) are clocked by a gated clock enabled by `accept | hold_update`. rd_data_vld and wb_conflict are clocked by forever_cpuclk.

## Timing
- Read latency: request at cycle N, result visible on rd_data at N+1.
- A writeback in cycle N to the requested preg is returned at N+1. The preg register itself updates at the same edge, so no stale value is ever returned.
- Back-to-back accepts are possible every cycle when there is no stall: throughput 1/cycle.
- Reset values: rd_data_vld=0, rd_preg=0, rd_data=0, wb_conflict=0.
- Reset mid-hold discards the held result.
- Simultaneous events:
  - flush together with stall: the result is dropped.
  - flush together with rf_rd_vld: the request is not accepted.

## Configuration
- Macro: CT_IDU_PRF_RD_BYPASS_EN.
- Defined: writeback bypass on accept and hold-cycle result update, as above.
- Undefined: rd_data always comes from prf_preg_dout, and there is no hold update. Issue logic must not read a preg in its writeback cycle or while holding it.
- wb_conflict detection is present in both builds.

## Structure
- Shared package: PREG_NUM, PREG_W, DATA_W, and the wb port priority encoding constants.
- One sub-module: a `gated_clk_cell` instance `x_rd_port_gated_clk` for the data registers.
  - clk_in = forever_cpuclk
  - external_en = 0
  - global_en = cp0_yy_clk_en
  - module_en = cp0_idu_icg_en
  - local_en = accept | hold_update
- A per-port match function (vld & preg equality) is shared between accept and hold paths.

## Test plan
- Plain read: preg 5 = 0x1111, request preg 5 at cycle 10 -> at cycle 11 rd_data_vld=1, rd_preg=5, rd_data=0x1111. No request at cycle 11 -> rd_data_vld=0 at cycle 12.
- Same-cycle bypass: request preg 7 while pipe1 writes preg 7 with 0xABCD, array value 0x0 -> rd_data=0xABCD next cycle. With the macro undefined -> 0x0.
- Stall hold + update: result preg 9 = 0x22 held for 3 stall cycles, pipe3 writes preg 9 = 0x33 in the 2nd -> rd_data stays 0x22, then reads 0x33. The pending request is not accepted until the stall drops.
- Flush: flush asserted during a hold -> rd_data_vld=0 next edge. Flush with rf_rd_vld -> no result.
- Conflict: pipe0 and pipe3 both write preg 12 (0x1, 0x2) while preg 12 is requested -> rd_data=0x1, wb_conflict=1. It stays 1 until cpurst.
- Async reset: cpurst asserted mid-cycle while rd_data_vld=1 -> all outputs 0 immediately. Out-of-range request preg 100 -> rd_data=0.

Source files
------------

// File: rtl/ct_idu_rf_prf_rd_port_pkg.sv
// ----------------------------------------------------------------------------
// ct_idu_rf_prf_rd_port_pkg
// Shared constants and helpers for the IDU RF physical register file read port.
//   PREG_NUM / PREG_W / DATA_W : register file geometry.
//   wb_sel_e                   : which writeback port supplies a bypassed value.
//   wb_match / wb_pick         : per-port hit test and fixed-priority pick,
//                                shared by the accept path and the hold path.
// ----------------------------------------------------------------------------
package ct_idu_rf_prf_rd_port_pkg;

    localparam int PREG_NUM = 96;
    localparam int PREG_W   = 7;
    localparam int DATA_W   = 64;

    // Writeback source encoding; pipe0 has the highest priority, pipe3 the lowest.
    typedef enum logic [1:0] {
        WB_SEL_NONE  = 2'd0,
        WB_SEL_PIPE0 = 2'd1,
        WB_SEL_PIPE1 = 2'd2,
        WB_SEL_PIPE3 = 2'd3
    } wb_sel_e;

    function automatic logic wb_match(input logic              vld,
                                      input logic [PREG_W-1:0] wb_preg,
                                      input logic [PREG_W-1:0] preg);
        return vld & (wb_preg == preg);
    endfunction

    function automatic wb_sel_e wb_pick(input logic hit0,
                                        input logic hit1,
                                        input logic hit3);
        if (hit0)      return WB_SEL_PIPE0;
        else if (hit1) return WB_SEL_PIPE1;
        else if (hit3) return WB_SEL_PIPE3;
        else           return WB_SEL_NONE;
    endfunction

endpackage

// File: rtl/ct_idu_rf_prf_rd_port_if.sv
// ----------------------------------------------------------------------------
// ct_idu_rf_prf_rd_port_if
// Request/response bundle of one PRF read port.
//   rf_flush, rf_rd_vld, rf_rd_preg, rf_rd_stall : issue side -> read port
//   rd_data_vld, rd_preg, rd_data, wb_conflict   : read port -> consumer
//
// Handshake: a request transfers on a clock edge where rf_rd_vld=1,
// rf_flush=0 and the port is not holding (not rd_data_vld & rf_rd_stall);
// otherwise upstream must keep presenting it. rf_rd_stall acts as an
// inverted ready for the result: while rd_data_vld & rf_rd_stall the result
// (rd_preg/rd_data) stays presented. rf_flush drops the result and any
// request on the same edge.
// ----------------------------------------------------------------------------
interface ct_idu_rf_prf_rd_port_if
    import ct_idu_rf_prf_rd_port_pkg::*;
#(
    parameter int P_PREG_W = PREG_W,
    parameter int P_DATA_W = DATA_W
) ();

    logic                rf_flush;
    logic                rf_rd_vld;
    logic [P_PREG_W-1:0] rf_rd_preg;
    logic                rf_rd_stall;
    logic                rd_data_vld;
    logic [P_PREG_W-1:0] rd_preg;
    logic [P_DATA_W-1:0] rd_data;
    logic                wb_conflict;

    modport master (
        output rf_flush, rf_rd_vld, rf_rd_preg, rf_rd_stall,
        input  rd_data_vld, rd_preg, rd_data, wb_conflict
    );

    modport slave (
        input  rf_flush, rf_rd_vld, rf_rd_preg, rf_rd_stall,
        output rd_data_vld, rd_preg, rd_data, wb_conflict
    );

endinterface

// File: rtl/ct_idu_rf_prf_rd_port_gated_clk_cell.sv
// ----------------------------------------------------------------------------
// gated_clk_cell
// Latch-based clock gate.
//   clk_in             : free-running clock
//   global_en          : global gating enable (must be 1 for any clock)
//   module_en          : module-level enable, forces the clock on
//   local_en           : local functional enable
//   external_en        : unconditional enable
//   pad_yy_icg_scan_en : scan override
//   clk_out            : gated clock
// The enable is captured while clk_in is low so clk_out never glitches.
// ----------------------------------------------------------------------------
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en_af_latch;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    always_latch begin
        if (!clk_in) begin
            clk_en_af_latch <= clk_en_bf_latch | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & clk_en_af_latch;

endmodule

// File: rtl/ct_idu_rf_prf_rd_port.sv
// ----------------------------------------------------------------------------
// ct_idu_rf_prf_rd_port
// One registered read port of the integer physical register file.
// A request selects one preg; its value appears on rd_data one cycle later.
// Writebacks landing in the request cycle are bypassed, and a result held
// under consumer stall is refreshed by matching writebacks.
//
// Ports:
//   forever_cpuclk, cpurst           : clock, async active-high reset
//   cp0_idu_icg_en, cp0_yy_clk_en,
//   pad_yy_icg_scan_en               : clock-gating controls
//   rd (slave modport)               : request/response bundle
//   prf_preg_dout                    : flattened preg outputs, preg i at [i*64 +: 64]
//   *_wb_preg_vld/_preg/_data        : pipe0, pipe1, pipe3 writebacks
//
// Configuration macro: CT_IDU_PRF_RD_BYPASS_EN
//   defined   : writeback bypass on accept plus result update during hold.
//   undefined : rd_data always taken from prf_preg_dout, no hold update.
// wb_conflict (two valid writebacks to one preg, sticky) exists in both builds.
// ----------------------------------------------------------------------------
module ct_idu_rf_prf_rd_port
    import ct_idu_rf_prf_rd_port_pkg::*;
#(
    parameter int PREG_NUM = ct_idu_rf_prf_rd_port_pkg::PREG_NUM,
    parameter int PREG_W   = ct_idu_rf_prf_rd_port_pkg::PREG_W,
    parameter int DATA_W   = ct_idu_rf_prf_rd_port_pkg::DATA_W
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    input  logic                     cp0_idu_icg_en,
    input  logic                     cp0_yy_clk_en,
    input  logic                     pad_yy_icg_scan_en,
    ct_idu_rf_prf_rd_port_if.slave   rd,
    input  logic [PREG_NUM*DATA_W-1:0] prf_preg_dout,
    input  logic                     iu_idu_ex2_pipe0_wb_preg_vld,
    input  logic [PREG_W-1:0]        iu_idu_ex2_pipe0_wb_preg,
    input  logic [DATA_W-1:0]        iu_idu_ex2_pipe0_wb_preg_data,
    input  logic                     iu_idu_ex2_pipe1_wb_preg_vld,
    input  logic [PREG_W-1:0]        iu_idu_ex2_pipe1_wb_preg,
    input  logic [DATA_W-1:0]        iu_idu_ex2_pipe1_wb_preg_data,
    input  logic                     lsu_idu_wb_pipe3_wb_preg_vld,
    input  logic [PREG_W-1:0]        lsu_idu_wb_pipe3_wb_preg,
    input  logic [DATA_W-1:0]        lsu_idu_wb_pipe3_wb_preg_data
);

    localparam logic [PREG_W:0] PREG_LIMIT = PREG_NUM[PREG_W:0];

    logic                rd_data_vld_q;
    logic [PREG_W-1:0]   rd_preg_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                wb_conflict_q;

    logic                accept;
    logic                hold;
    logic                hold_update;
    logic                data_clk;
    logic                conflict_now;
    logic                req_in_range;
    wb_sel_e             acc_sel;
    wb_sel_e             hold_sel;
    logic [DATA_W-1:0]   prf_arr [PREG_NUM];
    logic [DATA_W-1:0]   acc_data;
    logic [DATA_W-1:0]   hold_data;

    for (genvar i = 0; i < PREG_NUM; i++) begin : g_prf_unpack
        assign prf_arr[i] = prf_preg_dout[i*DATA_W +: DATA_W];
    end

    // Picks the writeback data named by sel, or the fallback when no port hit.
    function automatic logic [DATA_W-1:0] wb_mux(input wb_sel_e           sel,
                                                 input logic [DATA_W-1:0] fallback);
        case (sel)
            WB_SEL_PIPE0: return iu_idu_ex2_pipe0_wb_preg_data;
            WB_SEL_PIPE1: return iu_idu_ex2_pipe1_wb_preg_data;
            WB_SEL_PIPE3: return lsu_idu_wb_pipe3_wb_preg_data;
            default:      return fallback;
        endcase
    endfunction

    assign accept = rd.rf_rd_vld & ~(rd_data_vld_q & rd.rf_rd_stall) & ~rd.rf_flush;
    assign hold   = rd_data_vld_q & rd.rf_rd_stall & ~rd.rf_flush;

`ifdef CT_IDU_PRF_RD_BYPASS_EN
    assign acc_sel  = wb_pick(
        wb_match(iu_idu_ex2_pipe0_wb_preg_vld, iu_idu_ex2_pipe0_wb_preg, rd.rf_rd_preg),
        wb_match(iu_idu_ex2_pipe1_wb_preg_vld, iu_idu_ex2_pipe1_wb_preg, rd.rf_rd_preg),
        wb_match(lsu_idu_wb_pipe3_wb_preg_vld, lsu_idu_wb_pipe3_wb_preg, rd.rf_rd_preg));
    assign hold_sel = wb_pick(
        wb_match(iu_idu_ex2_pipe0_wb_preg_vld, iu_idu_ex2_pipe0_wb_preg, rd_preg_q),
        wb_match(iu_idu_ex2_pipe1_wb_preg_vld, iu_idu_ex2_pipe1_wb_preg, rd_preg_q),
        wb_match(lsu_idu_wb_pipe3_wb_preg_vld, lsu_idu_wb_pipe3_wb_preg, rd_preg_q));
`else
    assign acc_sel  = WB_SEL_NONE;
    assign hold_sel = WB_SEL_NONE;
`endif

    // Out-of-range indices read as zero and never take a bypass.
    assign req_in_range = {1'b0, rd.rf_rd_preg} < PREG_LIMIT;
    assign acc_data     = req_in_range ? wb_mux(acc_sel, prf_arr[rd.rf_rd_preg]) : '0;
    assign hold_data    = wb_mux(hold_sel, rd_data_q);
    assign hold_update  = hold & (hold_sel != WB_SEL_NONE);

    assign conflict_now =
        (wb_match(iu_idu_ex2_pipe0_wb_preg_vld, iu_idu_ex2_pipe0_wb_preg, iu_idu_ex2_pipe1_wb_preg) & iu_idu_ex2_pipe1_wb_preg_vld) |
        (wb_match(iu_idu_ex2_pipe0_wb_preg_vld, iu_idu_ex2_pipe0_wb_preg, lsu_idu_wb_pipe3_wb_preg) & lsu_idu_wb_pipe3_wb_preg_vld) |
        (wb_match(iu_idu_ex2_pipe1_wb_preg_vld, iu_idu_ex2_pipe1_wb_preg, lsu_idu_wb_pipe3_wb_preg) & lsu_idu_wb_pipe3_wb_preg_vld);

    gated_clk_cell x_rd_port_gated_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_idu_icg_en),
        .local_en           (accept | hold_update),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (data_clk)
    );

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_data_vld_q <= 1'b0;
            wb_conflict_q <= 1'b0;
        end else begin
            rd_data_vld_q <= accept | hold;
            if (conflict_now) begin
                wb_conflict_q <= 1'b1;
            end
        end
    end

    // The gate may be forced open by module_en, so the enables are repeated here.
    always_ff @(posedge data_clk or posedge cpurst) begin
        if (cpurst) begin
            rd_preg_q <= '0;
            rd_data_q <= '0;
        end else if (accept) begin
            rd_preg_q <= rd.rf_rd_preg;
            rd_data_q <= acc_data;
        end else if (hold_update) begin
            rd_data_q <= hold_data;
        end
    end

    assign rd.rd_data_vld = rd_data_vld_q;
    assign rd.rd_preg     = rd_preg_q;
    assign rd.rd_data     = rd_data_q;
    assign rd.wb_conflict = wb_conflict_q;

endmodule

// File: tb/tb_ct_idu_rf_prf_rd_port.sv
// ----------------------------------------------------------------------------
// tb_ct_idu_rf_prf_rd_port
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the read port (register file array, writeback
// priority list, expected output registers).
// ----------------------------------------------------------------------------
module tb_ct_idu_rf_prf_rd_port;
    import ct_idu_rf_prf_rd_port_pkg::*;

    localparam int NP = PREG_NUM;

    logic                   clk = 1'b0;
    logic                   cpurst = 1'b1;
    logic                   icg_en = 1'b0;
    logic                   clk_en = 1'b1;
    logic                   scan_en = 1'b0;
    logic [NP*DATA_W-1:0]   prf_flat;
    logic [DATA_W-1:0]      prf_mem [NP];

    // Writeback ports in priority order: [0]=pipe0, [1]=pipe1, [2]=pipe3.
    logic                   wb_vld  [3];
    logic [PREG_W-1:0]      wb_preg [3];
    logic [DATA_W-1:0]      wb_data [3];

    logic                   exp_vld;
    logic [PREG_W-1:0]      exp_preg;
    logic [DATA_W-1:0]      exp_data;
    logic                   exp_conflict;

    int n_assert = 0;
    int n_fail   = 0;

    ct_idu_rf_prf_rd_port_if rd_if ();

    always #5 clk = ~clk;

    always_comb begin
        prf_flat = '0;
        for (int i = 0; i < NP; i++) prf_flat[i*DATA_W +: DATA_W] = prf_mem[i];
    end

    ct_idu_rf_prf_rd_port dut (
        .forever_cpuclk                (clk),
        .cpurst                        (cpurst),
        .cp0_idu_icg_en                (icg_en),
        .cp0_yy_clk_en                 (clk_en),
        .pad_yy_icg_scan_en            (scan_en),
        .rd                            (rd_if),
        .prf_preg_dout                 (prf_flat),
        .iu_idu_ex2_pipe0_wb_preg_vld  (wb_vld[0]),
        .iu_idu_ex2_pipe0_wb_preg      (wb_preg[0]),
        .iu_idu_ex2_pipe0_wb_preg_data (wb_data[0]),
        .iu_idu_ex2_pipe1_wb_preg_vld  (wb_vld[1]),
        .iu_idu_ex2_pipe1_wb_preg      (wb_preg[1]),
        .iu_idu_ex2_pipe1_wb_preg_data (wb_data[1]),
        .lsu_idu_wb_pipe3_wb_preg_vld  (wb_vld[2]),
        .lsu_idu_wb_pipe3_wb_preg      (wb_preg[2]),
        .lsu_idu_wb_pipe3_wb_preg_data (wb_data[2])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".vld"},      64'(rd_if.rd_data_vld), 64'(exp_vld));
        chk({tag, ".preg"},     64'(rd_if.rd_preg),     64'(exp_preg));
        chk({tag, ".data"},     rd_if.rd_data,          exp_data);
        chk({tag, ".conflict"}, 64'(rd_if.wb_conflict), 64'(exp_conflict));
    endtask

    task automatic model_reset();
        exp_vld      = 1'b0;
        exp_preg     = '0;
        exp_data     = '0;
        exp_conflict = 1'b0;
    endtask

    // Returns the value a read of preg p would see this cycle.
    function automatic logic [DATA_W-1:0] value_seen(input logic [PREG_W-1:0] p,
                                                     input logic [DATA_W-1:0] fallback);
        logic [DATA_W-1:0] v;
        v = fallback;
`ifdef CT_IDU_PRF_RD_BYPASS_EN
        for (int i = 2; i >= 0; i--) begin
            if (wb_vld[i] && wb_preg[i] == p) v = wb_data[i];
        end
`endif
        return v;
    endfunction

    function automatic bit any_hit(input logic [PREG_W-1:0] p);
        bit h;
        h = 1'b0;
`ifdef CT_IDU_PRF_RD_BYPASS_EN
        for (int i = 0; i < 3; i++) if (wb_vld[i] && wb_preg[i] == p) h = 1'b1;
`endif
        return h;
    endfunction

    // Advances the expected outputs by one clock edge from the current inputs.
    task automatic model_next();
        bit acc, hld;
        acc = rd_if.rf_rd_vld && !(exp_vld && rd_if.rf_rd_stall) && !rd_if.rf_flush;
        hld = exp_vld && rd_if.rf_rd_stall && !rd_if.rf_flush;
        for (int i = 0; i < 3; i++)
            for (int j = i + 1; j < 3; j++)
                if (wb_vld[i] && wb_vld[j] && wb_preg[i] == wb_preg[j]) exp_conflict = 1'b1;
        if (acc) begin
            exp_preg = rd_if.rf_rd_preg;
            if (int'(rd_if.rf_rd_preg) >= NP) exp_data = '0;
            else exp_data = value_seen(rd_if.rf_rd_preg, prf_mem[rd_if.rf_rd_preg]);
        end else if (hld && any_hit(exp_preg)) begin
            exp_data = value_seen(exp_preg, exp_data);
        end
        exp_vld = acc || hld;
    endtask

    // One clock: predict, clock, retire writebacks into the array, compare.
    task automatic step(input string tag);
        model_next();
        @(posedge clk);
        #1;
        for (int i = 2; i >= 0; i--)
            if (wb_vld[i] && int'(wb_preg[i]) < NP) prf_mem[wb_preg[i]] = wb_data[i];
        check_outputs(tag);
    endtask

    task automatic idle();
        rd_if.rf_rd_vld   = 1'b0;
        rd_if.rf_rd_preg  = '0;
        rd_if.rf_rd_stall = 1'b0;
        rd_if.rf_flush    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_vld[i]  = 1'b0;
            wb_preg[i] = '0;
            wb_data[i] = '0;
        end
    endtask

    task automatic request(input int p);
        rd_if.rf_rd_vld  = 1'b1;
        rd_if.rf_rd_preg = PREG_W'(p);
    endtask

    task automatic wb(input int port, input int p, input logic [DATA_W-1:0] d);
        wb_vld[port]  = 1'b1;
        wb_preg[port] = PREG_W'(p);
        wb_data[port] = d;
    endtask

    initial begin
        logic [DATA_W-1:0] byp_exp;
        idle();
        model_reset();
        for (int i = 0; i < NP; i++) prf_mem[i] = {$urandom(), $urandom()};
        prf_mem[5]  = 64'h1111;
        prf_mem[7]  = 64'h0;
        prf_mem[9]  = 64'h22;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        cpurst = 1'b0;

        // Plain read and return to idle.
        request(5);
        step("plain_read");
        chk("plain_read.const", rd_if.rd_data, 64'h1111);
        idle();
        step("plain_idle");

        // Same-cycle bypass from pipe1.
        request(7);
        wb(1, 7, 64'hABCD);
`ifdef CT_IDU_PRF_RD_BYPASS_EN
        byp_exp = 64'hABCD;
`else
        byp_exp = 64'h0;
`endif
        step("bypass");
        chk("bypass.const", rd_if.rd_data, byp_exp);
        idle();

        // Stall hold with a pipe3 writeback in the second stall cycle.
        request(9);
        step("hold_read");
        request(3);
        rd_if.rf_rd_stall = 1'b1;
        step("hold_1");
        wb(2, 9, 64'h33);
        step("hold_2");
        wb_vld[2] = 1'b0;
        step("hold_3");
        chk("hold_3.preg_kept", 64'(rd_if.rd_preg), 64'd9);
        rd_if.rf_rd_stall = 1'b0;
        step("hold_release");
        chk("hold_release.preg", 64'(rd_if.rd_preg), 64'd3);
        idle();

        // Flush during hold, then flush together with a request.
        request(4);
        step("flush_read");
        rd_if.rf_rd_stall = 1'b1;
        rd_if.rf_flush    = 1'b1;
        step("flush_hold");
        rd_if.rf_rd_stall = 1'b0;
        step("flush_req");
        chk("flush_req.vld", 64'(rd_if.rd_data_vld), 64'd0);
        idle();

        // Conflicting writebacks from pipe0 and pipe3 to preg 12.
        request(12);
        wb(0, 12, 64'h1);
        wb(2, 12, 64'h2);
        step("conflict");
        chk("conflict.flag", 64'(rd_if.wb_conflict), 64'd1);
        idle();
        step("conflict_sticky1");
        step("conflict_sticky2");

        // Out-of-range request.
        request(100);
        step("oor");
        chk("oor.data", rd_if.rd_data, 64'h0);
        idle();

        // Asynchronous reset while a result is valid.
        request(20);
        step("pre_reset");
        idle();
        #2;
        cpurst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        cpurst = 1'b0;
        step("post_reset");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int p;
            icg_en            = 1'($urandom_range(0, 1));
            rd_if.rf_rd_vld   = ($urandom_range(0, 99) < 70);
            p                 = ($urandom_range(0, 19) == 0) ? int'($urandom_range(96, 127))
                                                             : int'($urandom_range(0, 15));
            rd_if.rf_rd_preg  = PREG_W'(p);
            rd_if.rf_rd_stall = ($urandom_range(0, 99) < 35);
            rd_if.rf_flush    = ($urandom_range(0, 99) < 8);
            for (int i = 0; i < 3; i++) begin
                wb_vld[i]  = ($urandom_range(0, 99) < 40);
                wb_preg[i] = PREG_W'($urandom_range(0, 15));
                wb_data[i] = {$urandom(), $urandom()};
            end
            step("random");
        end
        idle();
        step("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
